alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//  Downstream buffer for the 4-bit ALU: captures each ALU result (x) and flag (o)
//  on a valid/ready handshake and holds them in order until the consumer pops them.
//  Decouples the ALU issue rate from a slower sink. Provides count, full/empty and
//  a sticky overflow flag for results offered while full.
// PARAMETERS
//  DATA_W  4  width of ALU result x
//  DEPTH   8  number of entries; power of 2, >= 2
//  ADDR_W  3  log2(DEPTH); pointer width
// PORTS
//  clk        in   1         single clock; all state updates on rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         ALU result offered this cycle
//  in_ready   out  1         FIFO can accept (= !full)
//  in_x       in   DATA_W    ALU result x
//  in_o       in   1         ALU flag o
//  out_valid  out  1         head entry available (= !empty)
//  out_ready  in   1         consumer takes head this cycle
//  out_x      out  DATA_W    head result x
//  out_o      out  1         head flag o
//  count      out  ADDR_W+1  entries held, 0..DEPTH
//  full       out  1         count == DEPTH
//  empty      out  1         count == 0
//  ovf        out  1         sticky: in_valid seen while full
// BEHAVIOUR
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both sampled at posedge.
//  - Storage DEPTH x (DATA_W+1); wr_ptr/rd_ptr ADDR_W bits, wrap DEPTH-1 -> 0 naturally.
//  - count is registered: +1 on push only, -1 on pop only, unchanged on both/neither.
//  - First-word-fall-through: out_x/out_o driven from mem[rd_ptr] whenever !empty;
//    a push at edge N makes out_valid=1 in the cycle after edge N (latency 1).
//  - out_x/out_o are don't-care while empty; bench must not check them then.
//  - in_ready depends only on full (no combinational path from out_ready); a pop while
//    full frees a slot visible the next cycle, never the same cycle.
//  - Simultaneous push+pop with 0<count<DEPTH: both happen, count unchanged, order kept.
//  - Push+pop while empty: push accepted, no pop (out_valid=0).
//  - in_valid while full: data dropped, no state change except ovf<=1.
//  - ovf clears only on rst.
//  - Occupancy states: EMPTY (count=0) -> PARTIAL on push; PARTIAL -> FULL when count
//    reaches DEPTH; FULL -> PARTIAL on pop; PARTIAL -> EMPTY when count reaches 0.
//  - rst (synchronous, may assert mid-stream): next edge sets wr_ptr=rd_ptr=0, count=0,
//    ovf=0 -> empty=1, full=0, in_ready=1, out_valid=0; any push/pop that cycle ignored.
//    Memory contents not reset.
// CONFIGURATION
//  ALU_FIFO_OVF_CNT_EN defined: adds output ovf_cnt [7:0]; +1 on every in_valid cycle
//    while full, saturates at 255, cleared by rst to 0. ovf behaviour unchanged.
//  Not defined: ovf_cnt port and counter absent; only sticky ovf reports drops.
// TESTING
//  1. rst=1 one cycle -> count=0, empty=1, full=0, in_ready=1, out_valid=0, ovf=0.
//  2. Push x=0110,o=1 then x=1000,o=0 with out_ready=0 -> count=2; raise out_ready ->
//     pops 0110/1 then 1000/0, empty=1.
//  3. Push 8 results x=0000..0111 -> full=1, in_ready=0; 9th in_valid x=1111 -> ovf=1,
//     count=8; drain -> 0000..0111 in order, 1111 never appears.
//  4. count=3, push+pop same cycle for 10 cycles -> count stays 3, order kept across
//     pointer wrap.
//  5. count=5, assert rst with in_valid=out_ready=1 -> next cycle count=0, empty=1, ovf=0.
//  6. ALU_FIFO_OVF_CNT_EN: hold in_valid while full 260 cycles -> ovf_cnt=255; rst -> 0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Output buffer for the 4-bit ALU. Each result (x) and its flag (o) is taken
//   on a valid/ready handshake and held in order until the consumer pops it.
//   The buffer is first-word-fall-through: the head entry is driven on out_x/out_o
//   whenever out_valid is high. A sticky ovf flag records any result offered while
//   the buffer was full; that result is dropped.
//
// Parameters
//   DATA_W  width of ALU result x
//   DEPTH   number of entries (power of 2, >= 2)
//   ADDR_W  log2(DEPTH), pointer width
//
// Ports
//   clk        clock, all state changes on rising edge
//   rst        synchronous active-high reset (pointers, count, state, ovf)
//   in_valid   ALU result offered
//   in_ready   buffer can accept (not full)
//   in_x       ALU result x
//   in_o       ALU flag o
//   out_valid  head entry available (not empty)
//   out_ready  consumer takes the head entry
//   out_x      head result x
//   out_o      head flag o
//   count      entries held, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   ovf        sticky, set when in_valid is seen while full
//   ovf_cnt    (only with ALU_FIFO_OVF_CNT_EN defined) saturating count of
//              in_valid cycles seen while full
//
// Build option
//   ALU_FIFO_OVF_CNT_EN  adds the ovf_cnt output and its 8-bit saturating counter.

module alu_result_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic              in_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic              out_o,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
`ifdef ALU_FIFO_OVF_CNT_EN
    output logic              ovf,
    output logic [7:0]        ovf_cnt
`else
    output logic              ovf
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } occ_t;

    occ_t              state;
    occ_t              state_next;
    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   head;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              push;
    logic              pop;

    // in_ready comes only from registered state, so a pop while full never
    // opens a slot in the same cycle.
    assign full      = (state == S_FULL);
    assign empty     = (state == S_EMPTY);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head  = mem[rd_ptr];
    assign out_x = head[DATA_W-1:0];
    assign out_o = head[DATA_W];

    // Storage carries no reset; a stale entry is never visible because
    // out_valid gates it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_o, in_x};
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (push) state_next = S_PARTIAL;
            end
            S_PARTIAL: begin
                if (count_next == FULL_CNT)   state_next = S_FULL;
                else if (count_next == '0)    state_next = S_EMPTY;
            end
            S_FULL: begin
                if (pop) state_next = S_PARTIAL;
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            if (in_valid && full) ovf <= 1'b1;
        end
    end

`ifdef ALU_FIFO_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= 8'd0;
        end else if (in_valid && full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
//   Directed bench for alu_result_fifo. A reference model (count, ovf, and a
//   queue of expected entries) is updated alongside the stimulus; every popped
//   head entry is compared against the front of the queue.

module tb_alu_result_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic       in_o;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_x;
    logic       out_o;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
`ifdef ALU_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt;
    int         m_ovf_cnt;
`endif

    int         total;
    int         bad;
    int         m_count;
    logic       m_ovf;
    logic [4:0] exp_q [$];

    alu_result_fifo #(.DATA_W(4), .DEPTH(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_o      (in_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_o     (out_o),
        .count     (count),
        .full      (full),
        .empty     (empty),
`ifdef ALU_FIFO_OVF_CNT_EN
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
`else
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, compare the head if the model pops, advance the
    // model, then check the status outputs just after the edge.
    task automatic cycle(input logic v, input logic [3:0] x, input logic o,
                         input logic r, input logic rs);
        logic m_push;
        logic m_pop;
        in_valid  = v;
        in_x      = x;
        in_o      = o;
        out_ready = r;
        rst       = rs;
        m_push = v && (m_count < 8);
        m_pop  = r && (m_count > 0);
        if (!rs && m_pop) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scoreboard_underflow got=pop exp=none");
            end else begin
                chk("head_entry", {3'b000, out_o, out_x}, {3'b000, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (rs) begin
            m_count = 0;
            m_ovf   = 1'b0;
            exp_q.delete();
`ifdef ALU_FIFO_OVF_CNT_EN
            m_ovf_cnt = 0;
`endif
        end else begin
            if (v && m_count == 8) begin
                m_ovf = 1'b1;
`ifdef ALU_FIFO_OVF_CNT_EN
                if (m_ovf_cnt < 255) m_ovf_cnt++;
`endif
            end
            if (m_push) exp_q.push_back({o, x});
            m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
        end
        chk("count",     {4'b0, count},       8'(m_count));
        chk("full",      {7'b0, full},        {7'b0, (m_count == 8)});
        chk("empty",     {7'b0, empty},       {7'b0, (m_count == 0)});
        chk("in_ready",  {7'b0, in_ready},    {7'b0, (m_count != 8)});
        chk("out_valid", {7'b0, out_valid},   {7'b0, (m_count != 0)});
        chk("ovf",       {7'b0, ovf},         {7'b0, m_ovf});
`ifdef ALU_FIFO_OVF_CNT_EN
        chk("ovf_cnt",   ovf_cnt,             8'(m_ovf_cnt));
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_count = 0;
        m_ovf   = 1'b0;
`ifdef ALU_FIFO_OVF_CNT_EN
        m_ovf_cnt = 0;
`endif
        in_valid  = 1'b0;
        in_x      = 4'h0;
        in_o      = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;

        // Reset state
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_count_zero", {4'b0, count}, 8'd0);

        // Two pushes held, then drained in order
        cycle(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        chk("two_held", {4'b0, count}, 8'd2);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("drained_empty", {7'b0, empty}, 8'd1);

        // Push+pop while empty: only the push happens
        cycle(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Fill to full, offer a ninth result, then drain
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), i[0], 1'b0, 1'b0);
        chk("full_after_8", {7'b0, full}, 8'd1);
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        chk("ovf_after_drop", {7'b0, ovf}, 8'd1);
        // Pop while full with in_valid held: slot frees next cycle only
        cycle(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("empty_after_drain", {7'b0, empty}, 8'd1);

        // Simultaneous push+pop at count=3 across pointer wrap
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'(4'h9 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i * 3), i[1], 1'b1, 1'b0);
        chk("steady_count3", {4'b0, count}, 8'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Mid-stream reset at count=5 with push and pop requested
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(4'hF - i), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'h7, 1'b0, 1'b1, 1'b1);
        chk("rst_mid_count", {4'b0, count}, 8'd0);
        chk("rst_mid_ovf", {7'b0, ovf}, 8'd0);
        cycle(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

`ifdef ALU_FIFO_OVF_CNT_EN
        // Saturating drop counter
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) cycle(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        chk("ovf_cnt_sat", ovf_cnt, 8'd255);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("ovf_cnt_rst", ovf_cnt, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
